alu_mc: RTL and testbench

//   Parametrised multi-cycle ALU for the LITE-16 execute stage. Single-cycle ops (add/sub/logic) plus

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_mc_if.sv | 31 +++
 rtl/alu_iter_unit.sv | 79 +++++++
 rtl/alu_mc.sv | 174 +++++++++++++++++
 tb/tb_alu_mc.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the LITE-16 multi-cycle ALU.
//   Opcode and compare-mode encodings, FSM state encoding, iterative-unit
//   operation kinds and bit positions inside the 4-bit flags word.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [1:0] CMP_EQ   = 2'b00;
    localparam logic [1:0] CMP_LT   = 2'b01;
    localparam logic [1:0] CMP_GT   = 2'b10;
    localparam logic [1:0] CMP_TRUE = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        IT_SLL = 2'd0,
        IT_SRL = 2'd1,
        IT_SRA = 2'd2,
        IT_MUL = 2'd3
    } iter_kind_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU.
//   Request side : in_valid/in_ready handshake with op, a, b, cmp_mode, cmp_signed.
//   Response side: out_valid/out_ready handshake with r, flags, cmp, err.
//   master = requester/consumer (the core), slave = the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       cmp_mode;
    logic             cmp_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic [3:0]       flags;
    logic             cmp;
    logic             err;

    modport master (
        output in_valid, op, a, b, cmp_mode, cmp_signed, out_ready,
        input  in_ready, out_valid, r, flags, cmp, err
    );

    modport slave (
        input  in_valid, op, a, b, cmp_mode, cmp_signed, out_ready,
        output in_ready, out_valid, r, flags, cmp, err
    );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative shift / shift-add multiply datapath.
//   clk, rst    : clock, synchronous active-high reset (aborts any operation)
//   start_i     : load operands and step count
//   kind_i      : SLL/SRL/SRA/MUL
//   steps_i     : number of steps to run (1..WIDTH)
//   a_i, b_i    : shift value / multiplicand, multiplier
//   done_o      : the step performed this cycle is the last one
//   res_o       : value after this cycle's step (valid with done_o)
//   carry_o     : MUL only, high half of the product is nonzero
// One bit per cycle. done_o and res_o are combinational so the owner can
// register the final value on the same edge as the last step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  iter_kind_e       kind_i,
    input  logic [CW-1:0]    steps_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);
    iter_kind_e       kind_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // For MUL, {hi,lo} is the running product with the multiplier shifting
    // out of lo; for shifts only lo is used.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        addend = lo_q[0] ? mcand_q : {WIDTH{1'b0}};
        sum    = {1'b0, hi_q} + {1'b0, addend};
        case (kind_q)
            IT_SLL:  lo_d = {lo_q[WIDTH-2:0], 1'b0};
            IT_SRL:  lo_d = {1'b0, lo_q[WIDTH-1:1]};
            IT_SRA:  lo_d = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
            default: begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q  <= IT_SLL;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
        end else if (start_i) begin
            kind_q  <= kind_i;
            cnt_q   <= steps_i;
            lo_q    <= (kind_i == IT_MUL) ? b_i : a_i;
            hi_q    <= '0;
            mcand_q <= a_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            lo_q  <= lo_d;
            hi_q  <= hi_d;
        end
    end

    assign done_o  = (cnt_q == CW'(1));
    assign res_o   = lo_d;
    assign carry_o = (kind_q == IT_MUL) && (hi_d != '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the LITE-16 execute stage.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any in-flight operation
//   bus  : alu_mc_if.slave -- request (in_valid/in_ready, op, a, b, cmp_mode,
//          cmp_signed) and registered response (out_valid/out_ready, r,
//          flags {ovf,carry,neg,zero}, cmp, err)
// Single-cycle ops complete directly from IDLE/DONE; shifts with a nonzero
// amount and MUL go through ITER using alu_iter_unit. The compare bit is
// captured at accept for every op.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [3:0]       flags_q, flags_d;
    logic             cmp_q, cmp_d;
    logic             err_q, err_d;

    logic             accept;
    logic             is_shift, is_mul, start_iter;
    logic [CW-1:0]    shamt, steps;
    iter_kind_e       kind;

    logic [WIDTH-1:0] sc_r;
    logic             sc_c, sc_v, sc_err;
    logic [3:0]       sc_flags;
    logic             cmp_c;

    logic             it_done, it_carry;
    logic [WIDTH-1:0] it_res;
    logic [3:0]       it_flags;

    assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.r         = r_q;
    assign bus.flags     = flags_q;
    assign bus.cmp       = cmp_q;
    assign bus.err       = err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
    assign is_mul   = MUL_EN && (bus.op == OP_MUL);
    // Any amount >= WIDTH saturates to WIDTH steps, which shifts everything out.
    assign shamt    = (bus.b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : bus.b[CW-1:0];
    assign steps    = is_mul ? CW'(WIDTH) : shamt;
    // A zero-amount shift is just a pass-through and finishes in one cycle.
    assign start_iter = accept && (is_mul || (is_shift && shamt != '0));

    always_comb begin
        case (bus.op)
            OP_SLL:  kind = IT_SLL;
            OP_SRL:  kind = IT_SRL;
            OP_SRA:  kind = IT_SRA;
            default: kind = IT_MUL;
        endcase
    end

    // Single-cycle result; shifts land here only with a zero amount.
    always_comb begin
        sc_r   = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (bus.op)
            OP_ADD: begin
                {sc_c, sc_r} = {1'b0, bus.a} + {1'b0, bus.b};
                sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sc_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                {sc_c, sc_r} = {1'b0, bus.a} - {1'b0, bus.b};
                sc_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sc_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:                  sc_r = bus.a | bus.b;
            OP_XOR:                 sc_r = bus.a ^ bus.b;
            OP_AND:                 sc_r = bus.a & bus.b;
            OP_SLL, OP_SRL, OP_SRA: sc_r = bus.a;
            default:                sc_err = 1'b1;
        endcase
        sc_flags         = '0;
        sc_flags[FLAG_Z] = (sc_r == '0);
        sc_flags[FLAG_N] = sc_r[WIDTH-1] && !sc_err;
        sc_flags[FLAG_C] = sc_c;
        sc_flags[FLAG_V] = sc_v;
    end

    always_comb begin
        case (bus.cmp_mode)
            CMP_EQ:  cmp_c = (bus.a == bus.b);
            CMP_LT:  cmp_c = bus.cmp_signed ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
            CMP_GT:  cmp_c = bus.cmp_signed ? ($signed(bus.a) > $signed(bus.b)) : (bus.a > bus.b);
            default: cmp_c = 1'b1;
        endcase
    end

    always_comb begin
        it_flags         = '0;
        it_flags[FLAG_Z] = (it_res == '0);
        it_flags[FLAG_N] = it_res[WIDTH-1];
        it_flags[FLAG_C] = it_carry;
    end

    // Next state and result registers.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        flags_d = flags_q;
        cmp_d   = cmp_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = start_iter ? ST_ITER : ST_DONE;
            ST_ITER: begin
                if (it_done) begin
                    state_d = ST_DONE;
                    r_d     = it_res;
                    flags_d = it_flags;
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (accept)             state_d = start_iter ? ST_ITER : ST_DONE;
                else if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Accept never happens in ITER, so this cannot collide with the load above.
        if (accept) begin
            cmp_d = cmp_c;
            if (!start_iter) begin
                r_d     = sc_r;
                flags_d = sc_flags;
                err_d   = sc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            flags_q <= '0;
            cmp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            cmp_q   <= cmp_d;
            err_q   <= err_d;
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_iter),
        .kind_i  (kind),
        .steps_i (steps),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .done_o  (it_done),
        .res_o   (it_res),
        .carry_o (it_carry)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=16): the driver pushes hand-computed
// expectations with their due cycle, a monitor checks each presented result.
module tb_alu_mc;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mc_if #(.WIDTH(16)) bus ();

    alu_mc #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] r;
        logic [3:0]  f;
        logic        c;
        logic        e;
        int          due;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] mode, input logic sgn,
                         input logic [15:0] er, input logic [3:0] ef, input logic ec,
                         input logic ee, input int lat, input bit push_it);
        int guard = 0;
        bus.op = op; bus.a = a; bus.b = b; bus.cmp_mode = mode; bus.cmp_signed = sgn;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL %s: accept timeout, in_ready=%0b want 1", nm, bus.in_ready);
        end else if (push_it) begin
            q.push_back('{name: nm, r: er, f: ef, c: ec, e: ee, due: cyc + lat});
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk); guard++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d results outstanding, want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: sample well after the driver's negedge updates.
    initial begin
        exp_t cur;
        bit   shown = 0;
        bit   held  = 0;
        bit   have  = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                shown = 0; held = 0; have = 0;
            end else if (bus.out_valid) begin
                if (!shown) begin
                    shown = 1;
                    if (q.size() == 0) begin
                        total++; bad++; have = 0;
                        $display("FAIL unexpected_result: got r=%h with no request outstanding", bus.r);
                    end else begin
                        have = 1;
                        cur  = q[0];
                        chk({cur.name, "_latency"}, cyc, cur.due);
                        chk({cur.name, "_r"}, bus.r, cur.r);
                        chk({cur.name, "_flags"}, bus.flags, cur.f);
                        chk({cur.name, "_cmp"}, bus.cmp, cur.c);
                        chk({cur.name, "_err"}, bus.err, cur.e);
                    end
                end else if (held && have) begin
                    chk({cur.name, "_hold_r"}, bus.r, cur.r);
                    chk({cur.name, "_hold_flags"}, bus.flags, cur.f);
                end
                held = !bus.out_ready;
                if (bus.out_ready) begin
                    if (have) void'(q.pop_front());
                    shown = 0; have = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.a = '0; bus.b = '0; bus.cmp_mode = '0; bus.cmp_signed = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_r", bus.r, 0);
        chk("reset_flags", bus.flags, 0);
        chk("reset_cmp", bus.cmp, 0);
        chk("reset_err", bus.err, 0);
        @(negedge clk);

        //     name      op      a        b        mode      sgn   r        flags    c     e   lat
        issue("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, CMP_EQ,  1'b0, 16'h8000, 4'b1010, 1'b0, 1'b0, 1, 1);
        issue("sub_brw", OP_SUB, 16'h0000, 16'h0001, CMP_LT,  1'b0, 16'hFFFF, 4'b0110, 1'b1, 1'b0, 1, 1);
        issue("or",      OP_OR,  16'hF0F0, 16'h0FF0, CMP_TRUE,1'b0, 16'hFFF0, 4'b0010, 1'b1, 1'b0, 1, 1);
        issue("xor",     OP_XOR, 16'hF0F0, 16'h0FF0, CMP_TRUE,1'b0, 16'hFF00, 4'b0010, 1'b1, 1'b0, 1, 1);
        issue("and",     OP_AND, 16'hF0F0, 16'h0FF0, CMP_TRUE,1'b0, 16'h00F0, 4'b0000, 1'b1, 1'b0, 1, 1);
        drain();
        issue("sra3",    OP_SRA, 16'h8000, 16'd3,    CMP_GT,  1'b0, 16'hF000, 4'b0010, 1'b1, 1'b0, 4, 1);
        drain();
        issue("sra20",   OP_SRA, 16'h8000, 16'd20,   CMP_TRUE,1'b0, 16'hFFFF, 4'b0010, 1'b1, 1'b0, 17, 1);
        drain();
        issue("sll0",    OP_SLL, 16'h1234, 16'd0,    CMP_EQ,  1'b0, 16'h1234, 4'b0000, 1'b0, 1'b0, 1, 1);
        issue("sll15",   OP_SLL, 16'h0001, 16'd15,   CMP_EQ,  1'b0, 16'h8000, 4'b0010, 1'b0, 1'b0, 16, 1);
        drain();
        issue("srl4",    OP_SRL, 16'hF0F0, 16'd4,    CMP_GT,  1'b1, 16'h0F0F, 4'b0000, 1'b0, 1'b0, 5, 1);
        drain();
        issue("mul_hi",  OP_MUL, 16'h0100, 16'h0100, CMP_EQ,  1'b0, 16'h0000, 4'b0101, 1'b1, 1'b0, 17, 1);
        drain();
        issue("mul_lo",  OP_MUL, 16'h0003, 16'h0005, CMP_LT,  1'b1, 16'h000F, 4'b0000, 1'b1, 1'b0, 17, 1);
        drain();
        issue("lt_sgn",  OP_ADD, 16'hFFFF, 16'h0001, CMP_LT,  1'b1, 16'h0000, 4'b0101, 1'b1, 1'b0, 1, 1);
        issue("lt_uns",  OP_ADD, 16'hFFFF, 16'h0001, CMP_LT,  1'b0, 16'h0000, 4'b0101, 1'b0, 1'b0, 1, 1);
        issue("illegal", 4'd12,  16'h0005, 16'h0005, CMP_EQ,  1'b0, 16'h0000, 4'b0001, 1'b1, 1'b1, 1, 1);
        issue("after_il",OP_SUB, 16'h0005, 16'h0003, CMP_GT,  1'b1, 16'h0002, 4'b0000, 1'b1, 1'b0, 1, 1);
        drain();

        // Backpressure: result held for 5 cycles, then handoff and accept together.
        bus.out_ready = 1'b0;
        issue("bp_add",  OP_ADD, 16'h0001, 16'h0002, CMP_EQ,  1'b0, 16'h0003, 4'b0000, 1'b0, 1'b0, 1, 1);
        repeat (5) begin
            #1;
            chk("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        issue("bp_next", OP_XOR, 16'h0003, 16'h0003, CMP_EQ,  1'b0, 16'h0000, 4'b0001, 1'b1, 1'b0, 1, 1);
        drain();

        // Reset in the middle of a MUL: nothing may ever come out of it.
        issue("mul_abort", OP_MUL, 16'h1234, 16'h0011, CMP_EQ, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 17, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_r", bus.r, 0);
        chk("abort_flags", bus.flags, 0);
        repeat (25) @(negedge clk);

        issue("post_rst", OP_ADD, 16'h00FF, 16'h0001, CMP_GT, 1'b0, 16'h0100, 4'b0000, 1'b1, 1'b0, 1, 1);
        drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
